dual_slope_seq: RTL and testbench

//  Parametrised dual-slope ADC conversion sequencer for the MC14433-class model: N-digit BCD result,

---
 rtl/dual_slope_seq.sv | 178 +++++++++++++++++
 tb/tb_dual_slope_seq.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dual_slope_seq.sv
// Dual-slope ADC sequencer: AZ/INT/DEINT phases, N-digit BCD count, DU-gated latch.
// Define DSADC_SCAN_EN to add the multiplexed DS/Q digit-scan outputs.
module dual_slope_seq #(
  parameter int DIGITS     = 4,
  parameter int AZ_CYCLES  = 4000,
  parameter int INT_CYCLES = 2000,
  parameter int FS_LIMIT   = 1999,
  parameter int UR_LIMIT   = 180,
  parameter int SCAN_DIV   = 16
) (
  input  logic                CP,
  input  logic                R,
  input  logic                RUN,
  input  logic                CMP,
  input  logic                POL_IN,
  input  logic                DU,
  output logic                SW_AZ,
  output logic                SW_INT,
  output logic                SW_REF,
  output logic                EOC,
  output logic [4*DIGITS-1:0] BCD,
  output logic                POL,
  output logic                OR,
  output logic                UR
`ifdef DSADC_SCAN_EN
  ,
  output logic [DIGITS-1:0]   DS,
  output logic [3:0]          Q
`endif
);

  localparam int PMAX = (AZ_CYCLES > INT_CYCLES) ? AZ_CYCLES : INT_CYCLES;
  localparam int PW   = $clog2(PMAX + 1);
  localparam int BW   = $clog2(FS_LIMIT + 1);
  localparam int URC  = (UR_LIMIT > FS_LIMIT + 1) ? FS_LIMIT + 1 : UR_LIMIT;

  localparam logic [PW-1:0] AZ_LAST  = PW'(AZ_CYCLES - 1);
  localparam logic [PW-1:0] INT_LAST = PW'(INT_CYCLES - 1);
  localparam logic [BW-1:0] FS       = BW'(FS_LIMIT);
  localparam logic [BW:0]   URL      = (BW + 1)'(URC);

  typedef enum logic [2:0] {
    IDLE, AZ, INTG, DEINT, DONE
  } state_t;

  state_t              st;
  logic [PW-1:0]       ph;
  logic [BW-1:0]       bin;
  logic [4*DIGITS-1:0] cnt;
  logic                polw;

  // Ripple BCD increment: a digit wrapping 9->0 carries into the next one.
  function automatic logic [4*DIGITS-1:0] bcd_inc(
    input logic [4*DIGITS-1:0] v
  );
    logic [4*DIGITS-1:0] r;
    logic                c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (c) begin
        if (r[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = r[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  always_ff @(posedge CP) begin
    if (R) begin
      st     <= IDLE;
      ph     <= '0;
      bin    <= '0;
      cnt    <= '0;
      polw   <= 1'b0;
      SW_AZ  <= 1'b0;
      SW_INT <= 1'b0;
      SW_REF <= 1'b0;
      EOC    <= 1'b0;
      BCD    <= '0;
      POL    <= 1'b0;
      OR     <= 1'b0;
      UR     <= 1'b0;
    end else begin
      EOC <= 1'b0;
      unique case (st)
        IDLE: begin
          if (RUN) begin
            st    <= AZ;
            ph    <= '0;
            SW_AZ <= 1'b1;
          end
        end
        AZ: begin
          if (ph == AZ_LAST) begin
            st     <= INTG;
            ph     <= '0;
            SW_AZ  <= 1'b0;
            SW_INT <= 1'b1;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        INTG: begin
          if (ph == INT_LAST) begin
            st     <= DEINT;
            ph     <= '0;
            polw   <= POL_IN;
            bin    <= '0;
            cnt    <= '0;
            SW_INT <= 1'b0;
            SW_REF <= 1'b1;
          end else begin
            ph <= ph + 1'b1;
          end
        end
        DEINT: begin
          // CMP still high at full scale is the overrange exit.
          if (!CMP || bin == FS) begin
            st     <= DONE;
            SW_REF <= 1'b0;
            EOC    <= 1'b1;
            if (DU) begin
              BCD <= cnt;
              POL <= polw;
              OR  <= CMP;
              UR  <= ({1'b0, bin} < URL) && !CMP;
            end
          end else begin
            bin <= bin + 1'b1;
            cnt <= bcd_inc(cnt);
          end
        end
        DONE: begin
          if (RUN) begin
            st    <= AZ;
            ph    <= '0;
            SW_AZ <= 1'b1;
          end else begin
            st <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
    end
  end

`ifdef DSADC_SCAN_EN
  localparam int SDW = $clog2(SCAN_DIV + 1);
  localparam int SLW = $clog2(DIGITS + 1);

  localparam logic [SDW-1:0] SD_LAST = SDW'(SCAN_DIV - 1);
  localparam logic [SLW-1:0] MSD     = SLW'(DIGITS - 1);

  logic [SDW-1:0] sdiv;
  logic [SLW-1:0] sel;

  always_ff @(posedge CP) begin
    if (R) begin
      sdiv <= '0;
      sel  <= MSD;
    end else if (sdiv == SD_LAST) begin
      sdiv <= '0;
      sel  <= (sel == '0) ? MSD : sel - 1'b1;
    end else begin
      sdiv <= sdiv + 1'b1;
    end
  end

  assign DS = DIGITS'(1) << sel;
  assign Q  = BCD[4*sel +: 4];
`endif

endmodule

// File: tb/tb_dual_slope_seq.sv
// Scoreboard bench for dual_slope_seq at small parameters.
// Expected results are queued at stimulus time and popped on EOC.
module tb_dual_slope_seq;

  localparam int DIGITS = 2;

  logic                CP = 1'b0;
  logic                R, RUN, CMP, POL_IN, DU;
  logic                SW_AZ, SW_INT, SW_REF, EOC;
  logic [4*DIGITS-1:0] BCD;
  logic                POL, OR, UR;
`ifdef DSADC_SCAN_EN
  logic [DIGITS-1:0]   DS;
  logic [3:0]          Q;
`endif

  dual_slope_seq #(
    .DIGITS(DIGITS), .AZ_CYCLES(8), .INT_CYCLES(20),
    .FS_LIMIT(39), .UR_LIMIT(2), .SCAN_DIV(4)
  ) dut (
    .CP(CP), .R(R), .RUN(RUN), .CMP(CMP),
    .POL_IN(POL_IN), .DU(DU),
    .SW_AZ(SW_AZ), .SW_INT(SW_INT), .SW_REF(SW_REF),
    .EOC(EOC), .BCD(BCD), .POL(POL), .OR(OR), .UR(UR)
`ifdef DSADC_SCAN_EN
    , .DS(DS), .Q(Q)
`endif
  );

  always #5 CP = ~CP;

  typedef struct {
    logic [7:0] bcd;
    logic       pol;
    logic       ov;
    logic       ur;
    int         rlen;
  } exp_t;

  exp_t sb[$];

  int ncmp = 0;
  int nbad = 0;
  int neoc = 0;
  int nc_t = 0;
  int refk = 0;
  int az_run = 0, int_run = 0, ref_run = 0;
  int az_len = 0, int_len = 0, ref_len = 0;

  logic [7:0] m_bcd = '0;
  logic       m_pol = 1'b0, m_or = 1'b0, m_ur = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Comparator model: stays high for nc_t DEINT edges, then drops.
  always @(negedge CP) begin
    if (SW_REF) begin
      CMP = (refk < nc_t);
      refk++;
    end else begin
      refk = 0;
      CMP  = 1'b0;
    end
  end

  always @(negedge CP) begin
    exp_t e;
    if (SW_AZ) az_run++;
    else if (az_run > 0) begin az_len = az_run; az_run = 0; end
    if (SW_INT) int_run++;
    else if (int_run > 0) begin int_len = int_run; int_run = 0; end
    if (SW_REF) ref_run++;
    else if (ref_run > 0) begin ref_len = ref_run; ref_run = 0; end
    if (EOC) begin
      neoc++;
      if (sb.size() == 0) begin
        chk("eoc_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("bcd", BCD, e.bcd);
        chk("pol", POL, e.pol);
        chk("or", OR, e.ov);
        chk("ur", UR, e.ur);
        chk("ref_len", ref_len, e.rlen);
        chk("az_len", az_len, 8);
        chk("int_len", int_len, 20);
        chk("sw_in_done", {SW_AZ, SW_INT, SW_REF}, 0);
      end
    end
  end

  // mode 0: drop RUN in AZ, 1: drop RUN in INT, 2: keep RUN for back-to-back
  task automatic conv(input int nc, input bit pol, input bit du,
                      input int mode);
    exp_t e;
    int   cnt, k, e0;
    bit   ov;
    ov  = (nc >= 40);
    cnt = ov ? 39 : nc;
    if (du) begin
      m_bcd = 8'(((cnt / 10) << 4) | (cnt % 10));
      m_pol = pol;
      m_or  = ov;
      m_ur  = !ov && (cnt < 2);
    end
    e.bcd  = m_bcd;
    e.pol  = m_pol;
    e.ov   = m_or;
    e.ur   = m_ur;
    e.rlen = ov ? 40 : nc + 1;
    sb.push_back(e);
    POL_IN = pol;
    DU     = du;
    nc_t   = nc;
    RUN    = 1'b1;
    e0     = neoc;
    k = 0;
    while (!SW_AZ && k < 20) begin @(negedge CP); #1; k++; end
    if (!SW_AZ) chk("start_timeout", 0, 1);
    if (mode == 1) begin
      k = 0;
      while (!SW_INT && k < 40) begin @(negedge CP); #1; k++; end
      if (!SW_INT) chk("int_timeout", 0, 1);
    end
    if (mode != 2) RUN = 1'b0;
    k = 0;
    while (neoc == e0 && k < 200) begin @(negedge CP); #1; k++; end
    if (neoc == e0) chk("eoc_timeout", 0, 1);
    @(negedge CP); #1;
    if (mode == 2) begin
      chk("b2b_az", SW_AZ, 1);
    end else begin
      @(negedge CP); #1;
      chk("idle_sw", {SW_AZ, SW_INT, SW_REF, EOC}, 0);
    end
  endtask

  initial begin
    int k;
    R = 1'b1; RUN = 1'b0; POL_IN = 1'b0; DU = 1'b1; CMP = 1'b0;
    repeat (3) @(negedge CP);
    #1;
    chk("rst_ctl", {SW_AZ, SW_INT, SW_REF, EOC, POL, OR, UR}, 0);
    chk("rst_bcd", BCD, 0);
`ifdef DSADC_SCAN_EN
    chk("rst_ds", DS, 2'b10);
    chk("rst_q", Q, 0);
`endif
    R = 1'b0;

    conv(13, 1'b1, 1'b1, 0);
    conv(100, 1'b0, 1'b1, 0);
    conv(39, 1'b1, 1'b1, 0);
    conv(0, 1'b0, 1'b1, 0);
    conv(10, 1'b1, 1'b1, 0);
    conv(5, 1'b0, 1'b0, 0);
    conv(1, 1'b0, 1'b1, 1);
    conv(21, 1'b1, 1'b1, 2);
    conv(9, 1'b0, 1'b1, 0);

    // Reset while de-integrating aborts with no EOC and clears the result.
    nc_t = 30; DU = 1'b1; RUN = 1'b1;
    k = 0;
    while (!SW_REF && k < 60) begin @(negedge CP); #1; k++; end
    if (!SW_REF) chk("ref_timeout", 0, 1);
    repeat (4) @(negedge CP);
    R = 1'b1;
    @(negedge CP); #1;
    chk("abort_ctl", {SW_AZ, SW_INT, SW_REF, EOC}, 0);
    chk("abort_res", {BCD, POL, OR, UR}, 0);
    repeat (3) @(negedge CP);
    #1;
    chk("rst_run_idle", {SW_AZ, SW_INT, SW_REF}, 0);
    R = 1'b0; RUN = 1'b0;
    m_bcd = '0; m_pol = 1'b0; m_or = 1'b0; m_ur = 1'b0;
    repeat (3) @(negedge CP);
    #1;
    chk("post_rst_idle", {SW_AZ, EOC}, 0);

    conv(13, 1'b1, 1'b1, 0);
`ifdef DSADC_SCAN_EN
    k = 0;
    while (!(DS == 2'b01) && k < 20) begin @(negedge CP); #1; k++; end
    while (!(DS == 2'b10) && k < 40) begin @(negedge CP); #1; k++; end
    chk("scan_sync", DS, 2'b10);
    for (int c = 0; c < 16; c++) begin
      chk("scan_ds", DS, ((c % 8) < 4) ? 2'b10 : 2'b01);
      chk("scan_q", Q, ((c % 8) < 4) ? 1 : 3);
      @(negedge CP); #1;
    end
`endif
    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end

endmodule
